// File: rtl/pc_sequencer.sv
// Fetch program counter sequencer: sequential advance, redirect arbitration
// (trap > execute redirect > decode JAL), IF/ID flush generation, one bubble
// per redirect and a saturating redirect counter.
module pc_sequencer #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0100,
  parameter int          COUNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               imemReady,
  input  logic               idJal,
  input  logic [31:0]        idJalTarget,
  input  logic               exRedirect,
  input  logic [31:0]        exTarget,
  input  logic               trapReq,
  output logic [31:0]        pc,
  output logic               fetchValid,
  output logic               flushIF,
  output logic               flushID,
  output logic               misalignErr,
  output logic [COUNT_W-1:0] redirectCount
);

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc_next;
  logic        take_trap, take_ex, take_jal, accepted;
  logic        misalign;
  logic [31:0] target;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    if (&v) return v;
    return v + COUNT_W'(1);
  endfunction

  // Trap is taken unconditionally; the target check only applies to
  // computed redirect targets.
  function automatic logic is_misaligned(input logic [31:0] t);
    return t[1:0] != 2'b00;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= BOOT;
    else     state <= state_next;
  end

  // Redirect arbitration, flush generation and next-state/next-pc selection.
  always_comb begin
    take_trap  = 1'b0;
    take_ex    = 1'b0;
    take_jal   = 1'b0;
    target     = 32'h0;
    misalign   = 1'b0;
    accepted   = 1'b0;
    flushIF    = 1'b0;
    flushID    = 1'b0;
    state_next = state;
    pc_next    = pc;

    if (!rst && state != BOOT) begin
      // JAL only in RUN: in REDIRECT the decode slot holds a flushed instruction.
      take_trap = trapReq;
      take_ex   = exRedirect && !trapReq;
      take_jal  = idJal && !stall && (state == RUN) && !trapReq && !exRedirect;
    end

    if (take_ex)       target = exTarget;
    else if (take_jal) target = idJalTarget;

    misalign = (take_ex || take_jal) && is_misaligned(target);
    accepted = take_trap || take_ex || take_jal;

    flushIF = accepted;
    flushID = take_trap || take_ex || misalign;

    case (state)
      BOOT: state_next = RUN;
      RUN: begin
        if (accepted) begin
          state_next = REDIRECT;
          pc_next    = (take_trap || misalign) ? TRAP_VEC : target;
        end else if (!stall && imemReady) begin
          pc_next = pc + 32'd4;
        end
      end
      REDIRECT: begin
        if (accepted) pc_next = (take_trap || misalign) ? TRAP_VEC : target;
        else          state_next = RUN;
      end
      default: state_next = BOOT;
    endcase
  end

  // PC, redirect counter and registered misalignment pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= RESET_VEC;
      redirectCount <= '0;
      misalignErr   <= 1'b0;
    end else begin
      pc          <= pc_next;
      misalignErr <= misalign;
      if (accepted) redirectCount <= sat_inc(redirectCount);
    end
  end

  assign fetchValid = (state == RUN) && !rst;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed vectors push hand-computed
// expected outputs into a queue; a negedge monitor pops and compares.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst, stall, imemReady, idJal, exRedirect, trapReq;
  logic [31:0] idJalTarget, exTarget;

  logic [31:0] pc, pc_b;
  logic        fetchValid, flushIF, flushID, misalignErr;
  logic        fetchValid_b, flushIF_b, flushID_b, misalignErr_b;
  logic [15:0] redirectCount;
  logic [1:0]  redirectCount_b;

  typedef struct {
    logic [31:0] pc;
    logic        fv, fif, fid, mis;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .stall(stall), .imemReady(imemReady),
    .idJal(idJal), .idJalTarget(idJalTarget), .exRedirect(exRedirect),
    .exTarget(exTarget), .trapReq(trapReq), .pc(pc), .fetchValid(fetchValid),
    .flushIF(flushIF), .flushID(flushID), .misalignErr(misalignErr),
    .redirectCount(redirectCount)
  );

  pc_sequencer #(.COUNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .stall(stall), .imemReady(imemReady),
    .idJal(idJal), .idJalTarget(idJalTarget), .exRedirect(exRedirect),
    .exTarget(exTarget), .trapReq(trapReq), .pc(pc_b), .fetchValid(fetchValid_b),
    .flushIF(flushIF_b), .flushID(flushID_b), .misalignErr(misalignErr_b),
    .redirectCount(redirectCount_b)
  );

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every cycle with an expectation queued, compare at negedge.
  int mon_cyc = 0;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("pc",            mon_cyc, pc,                    e.pc);
      chk("fetchValid",    mon_cyc, 32'(fetchValid),       32'(e.fv));
      chk("flushIF",       mon_cyc, 32'(flushIF),          32'(e.fif));
      chk("flushID",       mon_cyc, 32'(flushID),          32'(e.fid));
      chk("misalignErr",   mon_cyc, 32'(misalignErr),      32'(e.mis));
      chk("redirectCount", mon_cyc, 32'(redirectCount),    32'(e.cnt));
      chk("count_w2",      mon_cyc, 32'(redirectCount_b),  32'(e.cnt2));
      mon_cyc++;
    end
  end

  // One cycle of stimulus plus the outputs expected during that cycle.
  task automatic step(input logic r, input logic st, input logic im,
                      input logic jal, input logic [31:0] jt,
                      input logic ex, input logic [31:0] et, input logic tr,
                      input logic [31:0] epc, input logic efv, input logic efi,
                      input logic efd, input logic emis,
                      input logic [15:0] ecnt, input logic [1:0] ecnt2);
    exp_t e;
    rst = r; stall = st; imemReady = im; idJal = jal; idJalTarget = jt;
    exRedirect = ex; exTarget = et; trapReq = tr;
    e.pc = epc; e.fv = efv; e.fif = efi; e.fid = efd; e.mis = emis;
    e.cnt = ecnt; e.cnt2 = ecnt2;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; imemReady = 1'b1; idJal = 1'b0; idJalTarget = '0;
    exRedirect = 1'b0; exTarget = '0; trapReq = 1'b0;
    @(posedge clk);
    #1;
    //    rst st im jal jt            ex et            tr  pc            fv fi fd ms cnt c2
    step(1, 0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0000, 0, 0, 0, 0, 0, 0); // reset
    step(0, 0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0000, 0, 0, 0, 0, 0, 0); // BOOT
    step(0, 0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0000, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0004, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 32'h40,       0, 32'h0,        0, 32'h0000_0008, 1, 1, 0, 0, 0, 0); // JAL
    step(0, 0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0040, 0, 0, 0, 0, 1, 1); // bubble
    step(0, 0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0040, 1, 0, 0, 0, 1, 1);
    step(0, 1, 1, 1, 32'h40,       1, 32'h80,       0, 32'h0000_0044, 1, 1, 1, 0, 1, 1); // jal+ex+stall
    step(0, 0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0080, 0, 0, 0, 0, 2, 2);
    step(0, 1, 1, 1, 32'h40,       1, 32'h80,       1, 32'h0000_0080, 1, 1, 1, 0, 2, 2); // +trap
    step(0, 0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0100, 0, 0, 0, 0, 3, 3);
    step(0, 0, 1, 0, 32'h0,        1, 32'h82,       0, 32'h0000_0100, 1, 1, 1, 0, 3, 3); // misaligned ex
    step(0, 0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0100, 0, 0, 0, 1, 4, 3);
    step(0, 0, 1, 0, 32'h0,        1, 32'h10,       0, 32'h0000_0100, 1, 1, 1, 0, 4, 3);
    step(0, 0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0010, 0, 0, 0, 0, 5, 3);
    step(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0010, 1, 0, 0, 0, 5, 3); // imem not ready
    step(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0010, 1, 0, 0, 0, 5, 3);
    step(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0010, 1, 0, 0, 0, 5, 3);
    step(0, 0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0010, 1, 0, 0, 0, 5, 3);
    step(0, 0, 1, 0, 32'h0,        1, 32'hFFFF_FFFC, 0, 32'h0000_0014, 1, 1, 1, 0, 5, 3);
    step(0, 0, 1, 0, 32'h0,        0, 32'h0,        0, 32'hFFFF_FFFC, 0, 0, 0, 0, 6, 3);
    step(0, 0, 1, 0, 32'h0,        0, 32'h0,        0, 32'hFFFF_FFFC, 1, 0, 0, 0, 6, 3); // wrap
    step(0, 1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0000, 1, 0, 0, 0, 6, 3); // stall
    step(0, 1, 1, 1, 32'h40,       0, 32'h0,        0, 32'h0000_0000, 1, 0, 0, 0, 6, 3); // JAL blocked
    step(0, 0, 1, 1, 32'h22,       0, 32'h0,        0, 32'h0000_0000, 1, 1, 1, 0, 6, 3); // misaligned JAL
    step(0, 0, 1, 1, 32'h40,       0, 32'h0,        0, 32'h0000_0100, 0, 0, 0, 1, 7, 3); // JAL in REDIRECT
    step(0, 0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0100, 1, 1, 1, 0, 7, 3); // trap
    step(0, 0, 1, 0, 32'h0,        1, 32'h200,      0, 32'h0000_0100, 0, 1, 1, 0, 8, 3); // ex in REDIRECT
    step(1, 0, 1, 0, 32'h0,        1, 32'h300,      0, 32'h0000_0200, 0, 0, 0, 0, 9, 3); // rst in REDIRECT
    step(0, 0, 1, 0, 32'h0,        1, 32'h300,      0, 32'h0000_0000, 0, 0, 0, 0, 0, 0); // BOOT ignores ex
    step(0, 0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0000, 1, 0, 0, 0, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
